// File: rtl/memory_arbiter.sv
// Two-master arbiter (instruction fetch, load/store) in front of one single-port memory.
// Data normally wins; fetch is forced through after STARVE_LIMIT consecutive data grants.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ready,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [1:0]  data_mask,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_mask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } memory_mask_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_INSTR = 2'd1,
    BUSY_DATA  = 2'd2
  } state_t;

  state_t       state_q;
  logic [3:0]   starve_cnt_q;
  logic         mem_req_q;
  logic [31:0]  mem_addr_q;
  logic         mem_we_q;
  memory_mask_t mem_mask_q;
  logic [31:0]  mem_wdata_q;
  logic         instr_ready_q;
  logic         data_ready_q;
  logic [31:0]  instr_rdata_q;
  logic [31:0]  data_rdata_q;

  logic starved;
  logic grant_data;
  logic grant_instr;

  assign starved     = (starve_cnt_q == 4'(STARVE_LIMIT));
  assign grant_data  = data_req && !(instr_req && starved);
  assign grant_instr = instr_req && !grant_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      starve_cnt_q  <= 4'd0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_we_q      <= 1'b0;
      mem_mask_q    <= MEM_BYTE;
      mem_wdata_q   <= 32'd0;
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      instr_rdata_q <= 32'd0;
      data_rdata_q  <= 32'd0;
    end else begin
      // Ready outputs are single-cycle pulses unless re-armed below.
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            state_q     <= BUSY_DATA;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= data_addr;
            mem_we_q    <= data_we;
            mem_mask_q  <= memory_mask_t'(data_mask);
            mem_wdata_q <= data_wdata;
            if (instr_req && !starved) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end else if (grant_instr) begin
            state_q      <= BUSY_INSTR;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= instr_addr;
            mem_we_q     <= 1'b0;
            mem_mask_q   <= MEM_WORD;
            mem_wdata_q  <= 32'd0;
            starve_cnt_q <= 4'd0;
          end
        end
        BUSY_INSTR: begin
          if (mem_ack) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            instr_ready_q <= 1'b1;
            instr_rdata_q <= mem_rdata;
          end
        end
        BUSY_DATA: begin
          if (mem_ack) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            data_ready_q <= 1'b1;
            // Stores leave the last load result visible.
            if (!mem_we_q) begin
              data_rdata_q <= mem_rdata;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_q;
  assign instr_rdata = instr_rdata_q;
  assign data_ready  = data_ready_q;
  assign data_rdata  = data_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_mask    = mem_mask_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = (state_q != IDLE);

endmodule
